// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with saturating direction counters and zero-latency lookup.
// Define BTB_BYPASS_EN to forward a same-cycle update to a lookup of the same index.
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W = 2,
    localparam int IDX_W = $clog2(ENTRIES),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      lookup_pc,
    output logic             hit,
    output logic             predict_taken,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_index,
    input  logic             update_en,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             flush
);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(2 ** (CTR_W - 1) - 1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    logic [29:0]        target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];

    logic [IDX_W-1:0] upd_idx, lk_idx;
    logic [TAG_W-1:0] upd_tag, lk_tag;
    logic             unused_bits;

    assign upd_idx     = update_pc[IDX_W+1:2];
    assign upd_tag     = update_pc[31:IDX_W+2];
    assign lk_idx      = lookup_pc[IDX_W+1:2];
    assign lk_tag      = lookup_pc[31:IDX_W+2];
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_target[1:0]};

    // Post-update image of the entry addressed by update_pc.
    logic             upd_hit, upd_valid;
    logic [TAG_W-1:0] upd_tag_n;
    logic [29:0]      upd_target;
    logic [CTR_W-1:0] upd_ctr, cur_ctr;

    always_comb begin
        cur_ctr    = ctr_q[upd_idx];
        upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_valid  = valid_q[upd_idx] || update_taken;
        upd_tag_n  = (update_taken && !upd_hit) ? upd_tag : tag_q[upd_idx];
        upd_target = update_taken ? update_target[31:2] : target_q[upd_idx];
        upd_ctr    = !update_taken ? (upd_hit ? ((cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_ONE) : cur_ctr)
                   : !upd_hit ? CTR_WT
                   : ((cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_ONE);
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < ENTRIES; i++) ctr_d[i] = CTR_WNT;
        end else if (update_en) begin
            valid_d[upd_idx]  = upd_valid;
            tag_d[upd_idx]    = upd_tag_n;
            target_d[upd_idx] = upd_target;
            ctr_d[upd_idx]    = upd_ctr;
        end
    end

    // Tags and targets are don't-care while invalid, so reset leaves them alone.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    logic             fwd, lk_valid;
    logic [TAG_W-1:0] lk_tag_e;
    logic [29:0]      lk_target;
    logic [CTR_W-1:0] lk_ctr;

    always_comb begin
`ifdef BTB_BYPASS_EN
        fwd = update_en && !flush && nRST && (upd_idx == lk_idx);
`else
        fwd = 1'b0;
`endif
        lk_valid      = fwd ? upd_valid  : valid_q[lk_idx];
        lk_tag_e      = fwd ? upd_tag_n  : tag_q[lk_idx];
        lk_target     = fwd ? upd_target : target_q[lk_idx];
        lk_ctr        = fwd ? upd_ctr    : ctr_q[lk_idx];
        hit           = lk_valid && (lk_tag_e == lk_tag);
        predict_taken = hit && lk_ctr[CTR_W-1];
        pred_target   = hit ? {lk_target, 2'b00} : 32'h0;
        pred_index    = lk_idx;
    end
endmodule
